// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI lines and consumer handshake of the SPI receive stage
// slave modport (the receiver):
//   in  spi_cs_l, sclk, spi_data   raw SPI lines from the master
//   in  data_ack                   consumer has taken dataout
//   out dataout[WIDTH], data_valid holding register and its valid flag
//   out overrun, frame_err         sticky error flags
//   out bit_count[5], busy         frame progress
// master modport is the mirror image, for whatever drives the lines and consumes words.
interface spi_slave_rx_if #(parameter int WIDTH = 16);
    logic             spi_cs_l;
    logic             sclk;
    logic             spi_data;
    logic             data_ack;
    logic [WIDTH-1:0] dataout;
    logic             data_valid;
    logic             overrun;
    logic             frame_err;
    logic [4:0]       bit_count;
    logic             busy;
    modport slave (
        input  spi_cs_l, sclk, spi_data, data_ack,
        output dataout, data_valid, overrun, frame_err, bit_count, busy
    );
    modport master (
        output spi_cs_l, sclk, spi_data, data_ack,
        input  dataout, data_valid, overrun, frame_err, bit_count, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling SPI receiver, MSB-first deserialiser with valid/ack holding register
// Ports:
//   clk    system clock, all logic on its rising edge
//   reset  asynchronous, active-low
//   bus    spi_slave_rx_if.slave: SPI lines and data_ack in; dataout, data_valid,
//          overrun, frame_err, bit_count, busy out
// Parameters: WIDTH bits per frame (<= 31), SYNC_STAGES synchroniser depth (>= 2),
//             SAMPLE_EDGE 0 = sample on rising sclk, 1 = on falling sclk.
module spi_slave_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter bit SAMPLE_EDGE = 1'b0
) (
    input logic          clk,
    input logic          reset,
    spi_slave_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, WAIT_CS} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_q, sclk_q, data_q;
    logic                   cs_s, sclk_s, data_s, sclk_d;
    logic                   samp, abort, done;
    logic [WIDTH-1:0]       shift, dout;
    logic [4:0]             cnt;
    logic                   busy_q, valid_q, ovr_q, ferr_q;

    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign data_s = data_q[SYNC_STAGES-1];
    assign samp   = SAMPLE_EDGE ? (sclk_d & ~sclk_s) : (sclk_s & ~sclk_d);
    // cs rising in the middle of a frame: the partial word is simply never loaded
    assign abort  = cs_s && state == RECV && cnt != 5'd0;

    // All three lines share the same depth so edges and data stay aligned;
    // the preset makes the first post-reset cycle look like an idle bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q   <= '1;
            sclk_q <= {SYNC_STAGES{SAMPLE_EDGE}};
            data_q <= '0;
            sclk_d <= SAMPLE_EDGE;
        end else begin
            cs_q   <= {cs_q[SYNC_STAGES-2:0], bus.spi_cs_l};
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.sclk};
            data_q <= {data_q[SYNC_STAGES-2:0], bus.spi_data};
            sclk_d <= sclk_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            shift  <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cs_s) begin
                state  <= IDLE;
                cnt    <= '0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= RECV;
                        busy_q <= 1'b1;
                    end
                    RECV: if (samp) begin
                        shift <= {shift[WIDTH-2:0], data_s};
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'(WIDTH - 1)) begin
                            state <= WAIT_CS;
                            done  <= 1'b1;
                        end
                    end
                    WAIT_CS: state <= WAIT_CS;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A completing word beats a same-cycle ack (valid stays set, no overrun);
    // error events likewise beat the ack that would clear their flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout    <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (done)
                dout <= shift;
            valid_q <= done | (valid_q & ~bus.data_ack);
            ovr_q   <= (done & valid_q & ~bus.data_ack) | (ovr_q & ~bus.data_ack);
            ferr_q  <= abort | (ferr_q & ~bus.data_ack);
        end
    end

    assign bus.dataout    = dout;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = ovr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.bit_count  = cnt;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: self-checking bench for spi_slave_rx against a frame-level reference model
module tb_spi_slave_rx;
    localparam int W = 16;
    localparam int S = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_slave_rx_if #(.WIDTH(W)) bus();
    spi_slave_rx #(.WIDTH(W), .SYNC_STAGES(S), .SAMPLE_EDGE(1'b0)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int passed = 0;
    int total = 0;
    logic [W-1:0] exp_data;
    logic exp_valid, exp_ovr, exp_ferr;
    logic [24:0] obs, e;
    assign obs = {bus.dataout, bus.data_valid, bus.overrun, bus.frame_err, bus.bit_count, bus.busy};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // MSB-first; with hold_last the task returns right after the final sclk rise
    task automatic send_bits(input logic [31:0] bits, input int n, input int half, input bit hold_last);
        for (int i = n - 1; i >= 0; i--) begin
            bus.spi_data = bits[i];
            tick(half);
            bus.sclk = 1'b1;
            if (i == 0 && hold_last) return;
            tick(half);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic open_cs();
        bus.spi_cs_l = 1'b0;
        tick(S + 3);
    endtask

    task automatic close_cs();
        bus.spi_cs_l = 1'b1;
        tick(S + 3);
    endtask

    task automatic model_reset();
        exp_data = '0;
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
    endtask

    // A frame of n bits: the first W bits form the word, extra bits are dropped,
    // fewer than W (but more than zero) is a framing error.
    task automatic model_frame(input logic [31:0] bits, input int n);
        logic [31:0] w;
        if (n >= W) begin
            w = bits >> (n - W);
            if (exp_valid) exp_ovr = 1'b1;
            exp_data = w[W-1:0];
            exp_valid = 1'b1;
        end else if (n > 0) begin
            exp_ferr = 1'b1;
        end
    endtask

    task automatic do_ack();
        bus.data_ack = 1'b1;
        tick(1);
        bus.data_ack = 1'b0;
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.spi_cs_l = 1'($urandom);
            bus.sclk = 1'($urandom);
            bus.spi_data = 1'($urandom);
            bus.data_ack = 1'($urandom);
            @(negedge clk);
            e = '0;
            if (obs !== e) $display("FAIL reset_hold obs=%h exp=%h", obs, e);
            else passed++;
            total++;
        end
        bus.spi_cs_l = 1'b1;
        bus.sclk = 1'b0;
        bus.spi_data = 1'b0;
        bus.data_ack = 1'b0;
        tick(1);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e = '0;
            if (obs !== e) $display("FAIL reset_idle obs=%h exp=%h", obs, e);
            else passed++;
            total++;
        end
        tick(1);
    endtask

    task automatic test_nominal();
        open_cs();
        send_bits(32'hA569, 16, 5, 1'b1);
        model_frame(32'hA569, 16);
        repeat (S + 1) @(posedge clk);
        @(negedge clk);
        if (bus.data_valid !== 1'b0) $display("FAIL nominal_early_valid got=%b exp=0", bus.data_valid);
        else passed++;
        total++;
        @(negedge clk);
        e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd16, 1'b1};
        if (obs !== e) $display("FAIL nominal_latency obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        repeat (2) @(posedge clk);
        #1;
        do_ack();
        @(negedge clk);
        e = {exp_data, 1'b0, 1'b0, 1'b0, 5'd16, 1'b1};
        if (obs !== e) $display("FAIL nominal_ack obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
        bus.sclk = 1'b0;
        tick(5);
        close_cs();
    endtask

    task automatic test_back_to_back();
        open_cs();
        send_bits(32'hA569, 16, 4, 1'b0);
        close_cs();
        model_frame(32'hA569, 16);
        open_cs();
        send_bits(32'h1234, 16, 4, 1'b0);
        close_cs();
        model_frame(32'h1234, 16);
        @(negedge clk);
        e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd0, 1'b0};
        if (obs !== e) $display("FAIL b2b_overrun obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
        do_ack();
        @(negedge clk);
        e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd0, 1'b0};
        if (obs !== e) $display("FAIL b2b_ack obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
    endtask

    task automatic test_abort();
        open_cs();
        send_bits(32'h7F, 7, 3, 1'b0);
        @(negedge clk);
        e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd7, 1'b1};
        if (obs !== e) $display("FAIL abort_partial obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
        close_cs();
        model_frame(32'h7F, 7);
        @(negedge clk);
        e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd0, 1'b0};
        if (obs !== e) $display("FAIL abort_flag obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
        open_cs();
        send_bits(32'h00FF, 16, 3, 1'b0);
        close_cs();
        model_frame(32'h00FF, 16);
        @(negedge clk);
        e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd0, 1'b0};
        if (obs !== e) $display("FAIL abort_next obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
        do_ack();
    endtask

    task automatic test_extra_clocks();
        open_cs();
        send_bits({12'h0, 16'hC3C3, 4'hF}, 20, 3, 1'b0);
        model_frame({12'h0, 16'hC3C3, 4'hF}, 20);
        tick(S + 2);
        @(negedge clk);
        e = {16'hC3C3, 1'b1, 1'b0, 1'b0, 5'd16, 1'b1};
        if (obs !== e) $display("FAIL extra_hold obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
        close_cs();
        @(negedge clk);
        e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd0, 1'b0};
        if (obs !== e) $display("FAIL extra_close obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
        do_ack();
    endtask

    task automatic test_zero_bits();
        open_cs();
        tick(4);
        close_cs();
        for (int i = 0; i < 4; i++) begin
            bus.sclk = ~bus.sclk;
            tick(3);
        end
        @(negedge clk);
        e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd0, 1'b0};
        if (obs !== e) $display("FAIL zero_bits obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
    endtask

    task automatic test_ack_collision();
        logic [31:0] w1, w2;
        w1 = {16'h0, 16'($urandom)};
        w2 = {16'h0, 16'($urandom)};
        open_cs();
        send_bits(w1, 16, 3, 1'b0);
        close_cs();
        model_frame(w1, 16);
        open_cs();
        send_bits(w2, 16, 3, 1'b1);
        repeat (S + 1) @(posedge clk);
        #1;
        bus.data_ack = 1'b1;
        tick(1);
        bus.data_ack = 1'b0;
        exp_data = w2[W-1:0];
        exp_valid = 1'b1;
        exp_ovr = 1'b0;
        @(negedge clk);
        e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd16, 1'b1};
        if (obs !== e) $display("FAIL ack_collision obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
        bus.sclk = 1'b0;
        tick(3);
        close_cs();
        do_ack();
    endtask

    task automatic test_async_reset();
        logic [31:0] w;
        w = {16'h0, 16'($urandom)};
        open_cs();
        send_bits(w, 16, 3, 1'b0);
        close_cs();
        model_frame(w, 16);
        open_cs();
        send_bits(32'($urandom), 9, 3, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        e = '0;
        if (obs !== e) $display("FAIL async_reset obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        model_reset();
        bus.spi_cs_l = 1'b1;
        bus.sclk = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        open_cs();
        send_bits(32'h5A5A, 16, 3, 1'b0);
        close_cs();
        model_frame(32'h5A5A, 16);
        @(negedge clk);
        e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd0, 1'b0};
        if (obs !== e) $display("FAIL async_after obs=%h exp=%h", obs, e);
        else passed++;
        total++;
        tick(1);
        do_ack();
    endtask

    task automatic test_random();
        logic [31:0] bits;
        int n, half;
        for (int k = 0; k < 12; k++) begin
            bits = $urandom;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16 + int'($urandom_range(0, 4));
            half = int'($urandom_range(2, 6));
            open_cs();
            send_bits(bits, n, half, 1'b0);
            close_cs();
            model_frame(bits, n);
            @(negedge clk);
            e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd0, 1'b0};
            if (obs !== e) $display("FAIL random_frame%0d n=%0d obs=%h exp=%h", k, n, obs, e);
            else passed++;
            total++;
            tick(1);
            if (exp_valid && $urandom_range(0, 1) == 1) begin
                do_ack();
                @(negedge clk);
                e = {exp_data, exp_valid, exp_ovr, exp_ferr, 5'd0, 1'b0};
                if (obs !== e) $display("FAIL random_ack%0d obs=%h exp=%h", k, obs, e);
                else passed++;
                total++;
                tick(1);
            end
        end
    endtask

    initial begin
        bus.spi_cs_l = 1'b1;
        bus.sclk = 1'b0;
        bus.spi_data = 1'b0;
        bus.data_ack = 1'b0;
        model_reset();
        test_reset();
        test_nominal();
        test_back_to_back();
        test_abort();
        test_extra_clocks();
        test_zero_bits();
        test_ack_collision();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d checks", total);
        $fatal(1);
    end
endmodule
